// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier scheduler.
// Imported by the scheduler top and its arbiter.
package mul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    localparam logic REQ_PIPE = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

    localparam int DEF_TIMEOUT = 32;

endpackage

// File: rtl/mul_rr_arbiter.sv
// Two-way round-robin arbiter for the multiplier requesters.
// The last pointer starts at REQ_AUX so the EX pipe wins first after reset.
module mul_rr_arbiter
    import mul_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       take,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= REQ_AUX;
        end else if (take) begin
            last <= gnt[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// Sequencer for the shared 16x16 Booth multiplier engine.
// Arbitrates two requesters, runs one engine op each, returns tagged results.
module mul_scheduler
    import mul_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_x,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_x,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush,
    output logic             eng_start,
    output logic [15:0]      eng_a,
    output logic [15:0]      eng_x,
    input  logic             eng_done,
    input  logic [31:0]      eng_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             rsp_err,
    output logic             busy
);

    state_t state, state_nx;

    logic [15:0]      a_q, x_q;
    logic [TAG_W-1:0] tag_q;
    logic             id_q, err_q;
    logic [31:0]      res_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0] eff_valid, gnt;
    logic       take, timeout_hit, kill, fin;
    logic       unused_hi;

    // The engine only consumes the low halves of the operands.
    assign unused_hi = ^{req0_a[31:16], req0_x[31:16],
                         req1_a[31:16], req1_x[31:16]};

    // Masking before arbitration lets requester 1 win while flush holds off 0.
    assign eff_valid = {req_valid[1], req_valid[0] & ~flush};

    mul_rr_arbiter u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (state == IDLE),
        .take  (take),
        .req   (eff_valid),
        .gnt   (gnt)
    );

    assign req_ready   = gnt;
    assign take        = |gnt;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign kill        = flush & (id_q == REQ_PIPE);
    assign fin         = eng_done | timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (take) state_nx = ISSUE;
            ISSUE: state_nx = kill ? DRAIN : WAIT;
            WAIT: begin
                if (kill) begin
                    state_nx = fin ? IDLE : DRAIN;
                end else if (fin) begin
                    state_nx = RESP;
                end
            end
            RESP:  if (kill || rsp_ready) state_nx = IDLE;
            DRAIN: if (fin) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        eng_start = (state == ISSUE);
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            x_q   <= '0;
            tag_q <= '0;
            id_q  <= 1'b0;
            res_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (state == IDLE && take) begin
                a_q   <= gnt[1] ? req1_a[15:0] : req0_a[15:0];
                x_q   <= gnt[1] ? req1_x[15:0] : req0_x[15:0];
                tag_q <= gnt[1] ? req1_tag : req0_tag;
                id_q  <= gnt[1];
            end
            if (state == ISSUE) begin
                cnt_q <= '0;
            end else if (state == WAIT || state == DRAIN) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Done beats a coincident timeout.
            if (state == WAIT && eng_done) begin
                res_q <= eng_result;
                err_q <= 1'b0;
            end else if (state == WAIT && timeout_hit) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
        end
    end

    assign eng_a      = a_q;
    assign eng_x      = x_q;
    assign rsp_id     = id_q;
    assign rsp_tag    = tag_q;
    assign rsp_result = res_q;
    assign rsp_err    = err_q;

endmodule

// File: doc/mul_scheduler.md
Name: mul_scheduler

Overview:
- Sequencing and arbitration controller for the shared 16x16 signed radix-4 Booth multiplier engine.
- Serves two requesters: requester 0 is the EX-stage MUL path; requester 1 is the secondary (DSP/MAC) port.
- For each request it latches the operands, issues one start pulse to the engine, waits for done (with a watchdog), and returns a tagged result over a valid/ready response channel.
- Sits between the decode/EX stall logic and the multiplier engine; owns all engine sequencing.

Parameters:
- TAG_W, 5, width of the request tag (destination rd index).
- TIMEOUT, 32, maximum WAIT cycles before the operation is declared failed.
- CNT_W, 6, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  request valid, one bit per requester.
- req_ready  out  2  request ready, one bit per requester.
- req0_a, req0_x  in  32 each  requester 0 operands.
- req1_a, req1_x  in  32 each  requester 1 operands.
- req0_tag, req1_tag  in  TAG_W each  request tags.
- flush  in  1  pipeline flush; kills requester-0 work.
- eng_start  out  1  one-cycle engine start pulse.
- eng_a, eng_x  out  16 each  engine operands.
- eng_done  in  1  engine result valid.
- eng_result  in  32  engine product.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_id  out  1  requester that owns the response.
- rsp_tag  out  TAG_W  tag of the response.
- rsp_result  out  32  product.
- rsp_err  out  1  watchdog timeout flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE; every output 0; round-robin pointer last=1, so requester 0 wins first; latched operands, tag, id and counter cleared.
- Reset mid-operation aborts immediately: no response is produced, and the engine shares the same reset.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - Grant = requester with valid set. If both are valid, grant the one that is not "last".
  - req_ready[g] = 1 only for the granted requester, and only in IDLE.
  - req_ready[0] is forced 0 while flush=1.
  - On valid&ready: latch a, x, tag and id; set last = id; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - eng_start = 1; eng_a = latched_a[15:0], eng_x = latched_x[15:0].
  - Counter cleared; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On eng_done: capture eng_result, set err=0, go to RESP.
  - When the counter reaches TIMEOUT without done: result = 0, err = 1, go to RESP.
  - If eng_done and the timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_tag, rsp_result and rsp_err are held stable until rsp_valid&rsp_ready.
  - After the handshake go to IDLE. A new request is accepted no earlier than the following cycle.
  - Minimum turnaround = engine latency + 3 cycles.
- flush (requester-0 ops only; no effect on requester 1 or in IDLE):
  - In ISSUE or WAIT: go to DRAIN.
  - In DRAIN: wait for eng_done or the timeout, discard the result, go to IDLE with no response. The engine is never aborted mid-operation.
  - In RESP: drop the response immediately (rsp_valid low next cycle) and go to IDLE.
- eng_done outside WAIT/DRAIN is ignored.
- Outputs eng_a, eng_x, eng_start, rsp_* and busy are registered or decoded from registered state only; no combinational path from req_valid to eng_*.
- Product semantics: engine computes the signed 16x16 product of the operands' lower halves, sign-extended to 32 bits. Upper operand bits are ignored.

Decomposition:
- Shared package mul_pkg:
  - state encoding enum (IDLE/ISSUE/WAIT/RESP/DRAIN);
  - requester id constants REQ_PIPE=0, REQ_AUX=1;
  - default TIMEOUT.
- One natural sub-module, mul_rr_arbiter: 2-way round-robin grant with a last pointer and an enable input.
- The rest (FSM, operand/response registers, watchdog counter) lives in mul_scheduler.

Test Plan:
- Basic op: req0 a=3, x=0xFFFFFFFE (-2), tag=7; engine model latency 8 -> one eng_start pulse with eng_a=0x0003, eng_x=0xFFFE; rsp_valid 1 cycle after done; rsp_result=0xFFFFFFFA, rsp_tag=7, rsp_id=0, rsp_err=0.
- Fairness: both requesters valid continuously -> grants alternate 0,1,0,1; the first grant after reset goes to 0.
- Backpressure: rsp_ready held low 5 cycles -> response fields stable throughout, req_ready stays 0, busy=1; accepted on the first ready cycle.
- Flush: flush during WAIT on a req0 op -> no rsp_valid; return to IDLE only after eng_done. Flush during a req1 op -> normal response delivered.
- Timeout: engine never asserts done -> after TIMEOUT=32 WAIT cycles rsp_valid=1, rsp_err=1, rsp_result=0.
- Reset mid-WAIT -> next cycle all outputs 0, state IDLE; a subsequent eng_done is ignored, and the next request completes normally.
